// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter in front of the shared bus slave side.
// Master 0 is the CPU and master 1 is the DMA-style requester. A granted
// master owns the bus until the slave acknowledges. Tie-breaking is either
// round-robin or fixed priority to master 0, selected by PRIO_FIXED.
// Optional transfer timeout: define BUS_ARBITER_TMO_EN to abort a grant that
// has waited TMO_CYCLES cycles for bus_ack.
//
//   state  | meaning
//   IDLE   | no owner, bus strobe low, waiting for a request
//   GRANT0 | master 0 owns the bus, slave side muxed from master 0
//   GRANT1 | master 1 owns the bus, slave side muxed from master 1
module bus_arbiter #(
  parameter bit          PRIO_FIXED = 1'b0,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic        owner,
  output logic        busy,
  output logic        tmo
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   expire;
  logic   done;

`ifdef BUS_ARBITER_TMO_EN
  logic [15:0] tmo_cnt;

  // Wait counter: restarts on every new grant, counts granted cycles without ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else if (state == IDLE || state_nxt != state) begin
      tmo_cnt <= 16'd0;
    end else if (!bus_ack) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A real ack in the expiry cycle wins, so expiry requires bus_ack low.
  assign expire = (state != IDLE) && !bus_ack && (tmo_cnt == 16'(TMO_CYCLES));
`else
  assign expire = 1'b0;
`endif

  assign tmo   = expire;
  assign done  = bus_ack | expire;
  assign busy  = (state != IDLE);
  assign owner = (state == GRANT1);

  // State and last-served register; last=1 out of reset so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration, completion handling and the slave-side data path mux.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    bus_stb   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 22'd0;
    bus_dout  = 32'd0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_din    = 32'd0;
    m1_din    = 32'd0;
    case (state)
      IDLE: begin
        if (m0_stb && m1_stb) begin
          state_nxt = (PRIO_FIXED || last) ? GRANT0 : GRANT1;
        end else if (m0_stb) begin
          state_nxt = GRANT0;
        end else if (m1_stb) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        bus_stb  = m0_stb & ~expire;
        bus_we   = m0_we;
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        m0_ack   = done;
        m0_din   = expire ? 32'd0 : bus_din;
        if (done) begin
          last_nxt  = 1'b0;
          state_nxt = m1_stb ? GRANT1 : IDLE;
        end else if (!m0_stb) begin
          state_nxt = IDLE;
        end
      end
      GRANT1: begin
        bus_stb  = m1_stb & ~expire;
        bus_we   = m1_we;
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        m1_ack   = done;
        m1_din   = expire ? 32'd0 : bus_din;
        if (done) begin
          last_nxt  = 1'b1;
          state_nxt = m0_stb ? GRANT0 : IDLE;
        end else if (!m1_stb) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter. DUT 0 is round-robin, DUT 1 fixed priority.
// Directed vector table, hand-written fixed-priority sequence, then random
// traffic checked against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int TMO = 4;
  localparam logic [21:0] A0 = 22'h000100;
  localparam logic [21:0] A1 = 22'h0003F0;
  localparam logic [31:0] D0 = 32'h12345678;
  localparam logic [31:0] D1 = 32'hCAFEBABE;

  typedef struct packed {
    logic rst, s0, we0; logic [21:0] a0; logic [31:0] d0;
    logic s1, we1; logic [21:0] a1; logic [31:0] d1;
    logic ack; logic [31:0] bdin;
  } in_t;

  typedef struct packed {
    logic stb, we; logic [21:0] addr; logic [31:0] dout;
    logic ack0; logic [31:0] din0; logic ack1; logic [31:0] din1;
    logic owner, busy, tmo;
  } out_t;

  typedef struct packed { logic stb, we; logic [21:0] addr; logic [31:0] dout; } mreq_t;

  typedef struct { logic rst, s0, s1, ack; int g; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic p0_rst, p0_m0_stb, p0_m0_we, p0_m0_ack, p0_m1_stb, p0_m1_we, p0_m1_ack;
  logic [21:0] p0_m0_addr, p0_m1_addr, p0_bus_addr;
  logic [31:0] p0_m0_dout, p0_m0_din, p0_m1_dout, p0_m1_din, p0_bus_dout, p0_bus_din;
  logic p0_bus_stb, p0_bus_we, p0_bus_ack, p0_owner, p0_busy, p0_tmo;

  logic p1_rst, p1_m0_stb, p1_m0_we, p1_m0_ack, p1_m1_stb, p1_m1_we, p1_m1_ack;
  logic [21:0] p1_m0_addr, p1_m1_addr, p1_bus_addr;
  logic [31:0] p1_m0_dout, p1_m0_din, p1_m1_dout, p1_m1_din, p1_bus_dout, p1_bus_din;
  logic p1_bus_stb, p1_bus_we, p1_bus_ack, p1_owner, p1_busy, p1_tmo;

  bus_arbiter #(.PRIO_FIXED(1'b0), .TMO_CYCLES(TMO)) u_rr (
    .clk(clk), .rst(p0_rst),
    .m0_stb(p0_m0_stb), .m0_we(p0_m0_we), .m0_addr(p0_m0_addr), .m0_dout(p0_m0_dout),
    .m0_din(p0_m0_din), .m0_ack(p0_m0_ack),
    .m1_stb(p0_m1_stb), .m1_we(p0_m1_we), .m1_addr(p0_m1_addr), .m1_dout(p0_m1_dout),
    .m1_din(p0_m1_din), .m1_ack(p0_m1_ack),
    .bus_stb(p0_bus_stb), .bus_we(p0_bus_we), .bus_addr(p0_bus_addr), .bus_dout(p0_bus_dout),
    .bus_din(p0_bus_din), .bus_ack(p0_bus_ack),
    .owner(p0_owner), .busy(p0_busy), .tmo(p0_tmo));

  bus_arbiter #(.PRIO_FIXED(1'b1), .TMO_CYCLES(TMO)) u_fx (
    .clk(clk), .rst(p1_rst),
    .m0_stb(p1_m0_stb), .m0_we(p1_m0_we), .m0_addr(p1_m0_addr), .m0_dout(p1_m0_dout),
    .m0_din(p1_m0_din), .m0_ack(p1_m0_ack),
    .m1_stb(p1_m1_stb), .m1_we(p1_m1_we), .m1_addr(p1_m1_addr), .m1_dout(p1_m1_dout),
    .m1_din(p1_m1_din), .m1_ack(p1_m1_ack),
    .bus_stb(p1_bus_stb), .bus_we(p1_bus_we), .bus_addr(p1_bus_addr), .bus_dout(p1_bus_dout),
    .bus_din(p1_bus_din), .bus_ack(p1_bus_ack),
    .owner(p1_owner), .busy(p1_busy), .tmo(p1_tmo));

  int checks = 0;
  int errors = 0;

  // reference model state per DUT: granted master (2 = none), last served, wait count
  int mg [2];
  int mlast [2];
  int mcnt [2];

  task automatic drv(input int d, input in_t i);
    if (d == 0) begin
      p0_rst = i.rst; p0_m0_stb = i.s0; p0_m0_we = i.we0; p0_m0_addr = i.a0; p0_m0_dout = i.d0;
      p0_m1_stb = i.s1; p0_m1_we = i.we1; p0_m1_addr = i.a1; p0_m1_dout = i.d1;
      p0_bus_ack = i.ack; p0_bus_din = i.bdin;
    end else begin
      p1_rst = i.rst; p1_m0_stb = i.s0; p1_m0_we = i.we0; p1_m0_addr = i.a0; p1_m0_dout = i.d0;
      p1_m1_stb = i.s1; p1_m1_we = i.we1; p1_m1_addr = i.a1; p1_m1_dout = i.d1;
      p1_bus_ack = i.ack; p1_bus_din = i.bdin;
    end
  endtask

  function automatic out_t rd(input int d);
    out_t o;
    if (d == 0)
      o = '{p0_bus_stb, p0_bus_we, p0_bus_addr, p0_bus_dout, p0_m0_ack, p0_m0_din,
            p0_m1_ack, p0_m1_din, p0_owner, p0_busy, p0_tmo};
    else
      o = '{p1_bus_stb, p1_bus_we, p1_bus_addr, p1_bus_dout, p1_m0_ack, p1_m0_din,
            p1_m1_ack, p1_m1_din, p1_owner, p1_busy, p1_tmo};
    return o;
  endfunction

  function automatic in_t mk_in(input logic rst, input logic s0, input logic s1,
                                input logic ack, input logic [31:0] bdin);
    in_t i;
    i = '{rst, s0, 1'b0, A0, D0, s1, 1'b1, A1, D1, ack, bdin};
    return i;
  endfunction

  // Expected outputs for a cycle given who holds the bus (g) and whether the wait expired.
  function automatic out_t exp_of(input in_t i, input int g, input logic expire);
    out_t e;
    e = '0;
    if (g == 0) begin
      e.stb = i.s0 & ~expire; e.we = i.we0; e.addr = i.a0; e.dout = i.d0;
      e.ack0 = i.ack | expire; e.din0 = expire ? 32'd0 : i.bdin; e.busy = 1'b1; e.owner = 1'b0;
    end else if (g == 1) begin
      e.stb = i.s1 & ~expire; e.we = i.we1; e.addr = i.a1; e.dout = i.d1;
      e.ack1 = i.ack | expire; e.din1 = expire ? 32'd0 : i.bdin; e.busy = 1'b1; e.owner = 1'b1;
    end
    e.tmo = expire;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input int d, input string tag, input out_t e);
    out_t a;
    a = rd(d);
    cmp({tag, ".bus_stb"},  32'(a.stb),  32'(e.stb));
    cmp({tag, ".bus_we"},   32'(a.we),   32'(e.we));
    cmp({tag, ".bus_addr"}, 32'(a.addr), 32'(e.addr));
    cmp({tag, ".bus_dout"}, a.dout,      e.dout);
    cmp({tag, ".m0_ack"},   32'(a.ack0), 32'(e.ack0));
    cmp({tag, ".m0_din"},   a.din0,      e.din0);
    cmp({tag, ".m1_ack"},   32'(a.ack1), 32'(e.ack1));
    cmp({tag, ".m1_din"},   a.din1,      e.din1);
    cmp({tag, ".busy"},     32'(a.busy), 32'(e.busy));
    cmp({tag, ".tmo"},      32'(a.tmo),  32'(e.tmo));
    if (e.busy) cmp({tag, ".owner"}, 32'(a.owner), 32'(e.owner));
  endtask

  // One directed cycle: drive after the falling edge, check 1 time unit later.
  task automatic row(input int d, input string tag, input logic rst, input logic s0,
                     input logic s1, input logic ack, input int g);
    in_t i;
    @(negedge clk);
    i = mk_in(rst, s0, s1, ack, $urandom);
    drv(d, i);
    #1;
    chk(d, tag, exp_of(i, g, 1'b0));
  endtask

  function automatic mreq_t gen_m(input mreq_t p, input logic acked);
    mreq_t n;
    n = p;
    if (p.stb && !acked) begin
      if ($urandom_range(0, 39) == 0) n.stb = 1'b0;
    end else begin
      n.stb  = 1'($urandom_range(0, 1));
      n.we   = 1'($urandom_range(0, 1));
      n.addr = 22'($urandom);
      n.dout = $urandom;
    end
    return n;
  endfunction

  // Rule-level model: who wins, when a transfer ends, where ownership goes next.
  task automatic model_step(input int d, input in_t i, input logic expire);
    int x;
    logic own_stb, oth_stb;
    if (i.rst) begin
      mg[d] = 2; mlast[d] = 1; mcnt[d] = 0;
    end else if (mg[d] == 2) begin
      if (i.s0 && i.s1) mg[d] = (d == 1) ? 0 : 1 - mlast[d];
      else if (i.s0) mg[d] = 0;
      else if (i.s1) mg[d] = 1;
      mcnt[d] = 0;
    end else begin
      x = mg[d];
      own_stb = (x == 0) ? i.s0 : i.s1;
      oth_stb = (x == 0) ? i.s1 : i.s0;
      if (i.ack || expire) begin
        mlast[d] = x;
        mg[d] = oth_stb ? 1 - x : 2;
        mcnt[d] = 0;
      end else if (!own_stb) begin
        mg[d] = 2; mcnt[d] = 0;
      end else begin
        mcnt[d]++;
      end
    end
  endtask

  vec_t vt [33];

  initial begin
    in_t idle_in;
    in_t cur [2];
    logic acked [2][2];
    mreq_t r0, r1;
    logic expire;
    out_t e;

    idle_in = mk_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    drv(0, idle_in);
    drv(1, idle_in);

    // {rst, m0_stb, m1_stb, bus_ack, granted master (2 = none)}
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vt[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
    vt[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
    vt[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vt[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 2};
    vt[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
    vt[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 2};
    vt[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 2};
    vt[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    vt[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 2};
    vt[28] = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
    vt[29] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
    vt[30] = '{1'b0, 1'b1, 1'b1, 1'b1, 0};
    vt[31] = '{1'b0, 1'b0, 1'b1, 1'b1, 1};
    vt[32] = '{1'b0, 1'b0, 1'b0, 1'b0, 2};

    repeat (2) @(negedge clk);
    drv(1, mk_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0));

    for (int i = 0; i < 33; i++)
      row(0, $sformatf("rr%0d", i), vt[i].rst, vt[i].s0, vt[i].s1, vt[i].ack, vt[i].g);
    drv(0, mk_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0));

    // fixed priority: master 0 wins every tie seen in IDLE, even right after it was served
    row(1, "fx0",  1'b1, 1'b0, 1'b0, 1'b0, 2);
    row(1, "fx1",  1'b0, 1'b1, 1'b0, 1'b0, 2);
    row(1, "fx2",  1'b0, 1'b1, 1'b0, 1'b0, 0);
    row(1, "fx3",  1'b0, 1'b1, 1'b0, 1'b1, 0);
    row(1, "fx4",  1'b0, 1'b1, 1'b1, 1'b0, 2);
    row(1, "fx5",  1'b0, 1'b1, 1'b1, 1'b0, 0);
    row(1, "fx6",  1'b0, 1'b1, 1'b1, 1'b1, 0);
    row(1, "fx7",  1'b0, 1'b0, 1'b1, 1'b1, 1);
    row(1, "fx8",  1'b0, 1'b1, 1'b1, 1'b0, 2);
    row(1, "fx9",  1'b0, 1'b1, 1'b1, 1'b0, 0);
    row(1, "fx10", 1'b0, 1'b1, 1'b1, 1'b1, 0);
    row(1, "fx11", 1'b0, 1'b0, 1'b1, 1'b1, 1);
    row(1, "fx12", 1'b0, 1'b0, 1'b1, 1'b0, 2);
    row(1, "fx13", 1'b0, 1'b0, 1'b1, 1'b1, 1);
    row(1, "fx14", 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // random traffic on both DUTs against the reference model
    for (int d = 0; d < 2; d++) begin
      cur[d] = mk_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      acked[d][0] = 1'b0; acked[d][1] = 1'b0;
      mg[d] = 2; mlast[d] = 1; mcnt[d] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        r0 = gen_m('{cur[d].s0, cur[d].we0, cur[d].a0, cur[d].d0}, acked[d][0]);
        r1 = gen_m('{cur[d].s1, cur[d].we1, cur[d].a1, cur[d].d1}, acked[d][1]);
        cur[d] = '{(c == 0) || ($urandom_range(0, 63) == 0),
                   r0.stb, r0.we, r0.addr, r0.dout, r1.stb, r1.we, r1.addr, r1.dout,
                   $urandom_range(0, 2) == 0, $urandom};
        drv(d, cur[d]);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
`ifdef BUS_ARBITER_TMO_EN
        expire = (mg[d] != 2) && !cur[d].ack && (mcnt[d] == TMO);
`else
        expire = 1'b0;
`endif
        e = exp_of(cur[d], mg[d], expire);
        chk(d, $sformatf("rnd%0d.d%0d", c, d), e);
        acked[d][0] = e.ack0;
        acked[d][1] = e.ack1;
        model_step(d, cur[d], expire);
      end
    end

`ifdef BUS_ARBITER_TMO_EN
    // no slave ack: abort fires in the fifth granted cycle, after four waiting cycles
    drv(1, mk_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    row(0, "to0", 1'b1, 1'b0, 1'b0, 1'b0, 2);
    row(0, "to1", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    for (int k = 0; k < TMO; k++)
      row(0, $sformatf("to_wait%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    cur[0] = mk_in(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    drv(0, cur[0]);
    #1;
    chk(0, "to_abort", exp_of(cur[0], 0, 1'b1));
    row(0, "to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
